mem_arbiter: RTL and testbench

Arbitrates the instruction-fetch unit (IFU) and the load/store unit (LSU) onto the core's single physical-memory port (the DPI pmem bridge). Each request side uses a valid/ready handshake. One transaction is outstanding at a time. The block sequences the memory port through a small FSM and routes each registered response back to the requester that issued it. It sits between the fetch/LSU stages of the multi-cycle core and the memory bridge.

---
 rtl/mem_arb_pkg.sv | 48 ++++
 rtl/mem_arbiter_if.sv | 52 +++++
 rtl/mem_arb_picker.sv | 91 +++++++++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM states, owner encoding,
// latched request record and grant encodings.
package mem_arb_pkg;

   localparam int unsigned MEM_ARB_ADDR_W  = 64;
   localparam int unsigned MEM_ARB_DATA_W  = 64;
   localparam int unsigned MEM_ARB_WMASK_W = MEM_ARB_DATA_W / 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWNER_IFU = 1'b0,
      OWNER_LSU = 1'b1
   } owner_e;

   typedef struct packed {
      logic [MEM_ARB_ADDR_W-1:0]  addr;
      logic                       wen;
      logic [MEM_ARB_DATA_W-1:0]  wdata;
      logic [MEM_ARB_WMASK_W-1:0] wmask;
   } mem_req_t;

   // Grant one-hot: bit 0 = IFU, bit 1 = LSU.
   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_IFU  = 2'b01;
   localparam logic [1:0] GRANT_LSU  = 2'b10;

   localparam mem_req_t MEM_REQ_CLEAR = '{
      addr:  {MEM_ARB_ADDR_W{1'b0}},
      wen:   1'b0,
      wdata: {MEM_ARB_DATA_W{1'b0}},
      wmask: {MEM_ARB_WMASK_W{1'b0}}
   };

   // Fetches are always reads: write enable and byte mask forced to zero.
   function automatic mem_req_t fetch_req_f(input logic [MEM_ARB_ADDR_W-1:0] addr);
      mem_req_t req;
      req      = MEM_REQ_CLEAR;
      req.addr = addr;
      return req;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the IFU, LSU, memory bridge and mem_arbiter.
// slave = arbiter side, master = requesters plus memory bridge side.
interface mem_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = MEM_ARB_ADDR_W,
   parameter int unsigned DATA_W = MEM_ARB_DATA_W
);

   logic                ifu_req_valid;
   logic                ifu_req_ready;
   logic [ADDR_W-1:0]   ifu_req_addr;
   logic                ifu_resp_valid;
   logic [DATA_W-1:0]   ifu_resp_data;

   logic                lsu_req_valid;
   logic                lsu_req_ready;
   logic [ADDR_W-1:0]   lsu_req_addr;
   logic                lsu_req_wen;
   logic [DATA_W-1:0]   lsu_req_wdata;
   logic [DATA_W/8-1:0] lsu_req_wmask;
   logic                lsu_resp_valid;
   logic [DATA_W-1:0]   lsu_resp_data;

   logic                mem_req_valid;
   logic                mem_req_ready;
   logic [ADDR_W-1:0]   mem_req_addr;
   logic                mem_req_wen;
   logic [DATA_W-1:0]   mem_req_wdata;
   logic [DATA_W/8-1:0] mem_req_wmask;
   logic                mem_resp_valid;
   logic [DATA_W-1:0]   mem_resp_data;

   modport slave (
      input  ifu_req_valid, ifu_req_addr,
      output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
      input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
      output lsu_req_ready, lsu_resp_valid, lsu_resp_data,
      output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
      input  mem_req_ready, mem_resp_valid, mem_resp_data
   );

   modport master (
      output ifu_req_valid, ifu_req_addr,
      input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
      output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
      input  lsu_req_ready, lsu_resp_valid, lsu_resp_data,
      input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
      output mem_req_ready, mem_resp_valid, mem_resp_data
   );

endinterface

// File: rtl/mem_arb_picker.sv
// Grant selection between IFU and LSU. MEM_ARB_ROUND_ROBIN_EN selects
// round-robin; otherwise LSU has fixed priority with an IFU starvation guard.
module mem_arb_picker
   import mem_arb_pkg::*;
#(
   parameter int unsigned IFU_STARVE_LIMIT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ifu_valid,
   input  logic       lsu_valid,
   input  logic       commit,
   output logic [1:0] grant
);

`ifdef MEM_ARB_ROUND_ROBIN_EN

   owner_e last_r;

   // On contention, the requester that was not granted last wins.
   always_comb begin
      grant = GRANT_NONE;
      if (ifu_valid && lsu_valid) begin
         if (last_r == OWNER_IFU) begin
            grant = GRANT_LSU;
         end else begin
            grant = GRANT_IFU;
         end
      end else if (ifu_valid) begin
         grant = GRANT_IFU;
      end else if (lsu_valid) begin
         grant = GRANT_LSU;
      end else begin
         grant = GRANT_NONE;
      end
   end

   // Last-grant pointer; reset value makes the IFU win the first contest.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_r <= OWNER_LSU;
      end else if (commit && grant[1]) begin
         last_r <= OWNER_LSU;
      end else if (commit && grant[0]) begin
         last_r <= OWNER_IFU;
      end else begin
         last_r <= last_r;
      end
   end

`else

   localparam int unsigned CNT_W = $clog2(IFU_STARVE_LIMIT + 2);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(IFU_STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt_r;

   // LSU first, unless the IFU has already lost LIMIT contests in a row.
   always_comb begin
      grant = GRANT_NONE;
      if (ifu_valid && lsu_valid) begin
         if (starve_cnt_r == LIMIT) begin
            grant = GRANT_IFU;
         end else begin
            grant = GRANT_LSU;
         end
      end else if (lsu_valid) begin
         grant = GRANT_LSU;
      end else if (ifu_valid) begin
         grant = GRANT_IFU;
      end else begin
         grant = GRANT_NONE;
      end
   end

   // Saturating count of LSU grants taken while the IFU was waiting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt_r <= {CNT_W{1'b0}};
      end else if (commit && grant[0]) begin
         starve_cnt_r <= {CNT_W{1'b0}};
      end else if (commit && grant[1] && ifu_valid && (starve_cnt_r != LIMIT)) begin
         starve_cnt_r <= starve_cnt_r + CNT_W'(1);
      end else begin
         starve_cnt_r <= starve_cnt_r;
      end
   end

`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter of IFU and LSU onto one memory port.
// Build option MEM_ARB_ROUND_ROBIN_EN switches the picker to round-robin.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned IFU_STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_arbiter_if.slave  bus
);

   arb_state_e                state_r;
   arb_state_e                state_next_s;
   logic [1:0]                grant_s;
   logic                      ifu_ready_s;
   logic                      lsu_ready_s;
   logic                      commit_s;
   logic                      resp_hit_s;
   mem_req_t                  req_r;
   owner_e                    owner_r;
   logic                      mem_req_valid_r;
   logic                      ifu_resp_valid_r;
   logic                      lsu_resp_valid_r;
   logic [MEM_ARB_DATA_W-1:0] ifu_resp_data_r;
   logic [MEM_ARB_DATA_W-1:0] lsu_resp_data_r;

   mem_arb_picker #(
      .IFU_STARVE_LIMIT (IFU_STARVE_LIMIT)
   ) u_picker (
      .clk       (clk),
      .rst_n     (rst_n),
      .ifu_valid (bus.ifu_req_valid),
      .lsu_valid (bus.lsu_req_valid),
      .commit    (commit_s),
      .grant     (grant_s)
   );

   // Ready goes to the winner only, only in IDLE and never while reset is held.
   always_comb begin
      ifu_ready_s = 1'b0;
      lsu_ready_s = 1'b0;
      if (rst_n && (state_r == ST_IDLE)) begin
         ifu_ready_s = grant_s[0];
         lsu_ready_s = grant_s[1];
      end else begin
         ifu_ready_s = 1'b0;
         lsu_ready_s = 1'b0;
      end
   end

   assign commit_s   = ifu_ready_s | lsu_ready_s;
   assign resp_hit_s = (state_r == ST_WAIT) && bus.mem_resp_valid;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next state; responses outside WAIT never move the FSM.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (commit_s) state_next_s = ST_ISSUE;
            else          state_next_s = ST_IDLE;
         end
         ST_ISSUE: begin
            if (bus.mem_req_ready) state_next_s = ST_WAIT;
            else                   state_next_s = ST_ISSUE;
         end
         ST_WAIT: begin
            if (bus.mem_resp_valid) state_next_s = ST_RESP;
            else                    state_next_s = ST_WAIT;
         end
         ST_RESP: state_next_s = ST_IDLE;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Latch the granted request and its owner; held stable until the next grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_r           <= MEM_REQ_CLEAR;
         owner_r         <= OWNER_IFU;
         mem_req_valid_r <= 1'b0;
      end else begin
         mem_req_valid_r <= (state_next_s == ST_ISSUE);
         if (ifu_ready_s) begin
            req_r   <= fetch_req_f(bus.ifu_req_addr);
            owner_r <= OWNER_IFU;
         end else if (lsu_ready_s) begin
            req_r   <= '{addr:  bus.lsu_req_addr,
                         wen:   bus.lsu_req_wen,
                         wdata: bus.lsu_req_wdata,
                         wmask: bus.lsu_req_wmask};
            owner_r <= OWNER_LSU;
         end else begin
            req_r   <= req_r;
            owner_r <= owner_r;
         end
      end
   end

   // Route the memory response to its owner; store acks carry zero data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifu_resp_valid_r <= 1'b0;
         lsu_resp_valid_r <= 1'b0;
         ifu_resp_data_r  <= {MEM_ARB_DATA_W{1'b0}};
         lsu_resp_data_r  <= {MEM_ARB_DATA_W{1'b0}};
      end else begin
         ifu_resp_valid_r <= resp_hit_s && (owner_r == OWNER_IFU);
         lsu_resp_valid_r <= resp_hit_s && (owner_r == OWNER_LSU);
         if (resp_hit_s && (owner_r == OWNER_IFU)) begin
            ifu_resp_data_r <= bus.mem_resp_data;
         end
         if (resp_hit_s && (owner_r == OWNER_LSU)) begin
            lsu_resp_data_r <= req_r.wen ? {MEM_ARB_DATA_W{1'b0}} : bus.mem_resp_data;
         end
      end
   end

   assign bus.ifu_req_ready  = ifu_ready_s;
   assign bus.lsu_req_ready  = lsu_ready_s;
   assign bus.ifu_resp_valid = ifu_resp_valid_r;
   assign bus.ifu_resp_data  = ifu_resp_data_r;
   assign bus.lsu_resp_valid = lsu_resp_valid_r;
   assign bus.lsu_resp_data  = lsu_resp_data_r;
   assign bus.mem_req_valid  = mem_req_valid_r;
   assign bus.mem_req_addr   = req_r.addr;
   assign bus.mem_req_wen    = req_r.wen;
   assign bus.mem_req_wdata  = req_r.wdata;
   assign bus.mem_req_wmask  = req_r.wmask;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; grant-order expectations
// follow MEM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   int   check_cnt = 0;
   int   pass_cnt  = 0;
   logic [9:0] exp_lsu_seq;

   mem_arbiter_if bus_if ();

   mem_arbiter #(
      .IFU_STARVE_LIMIT (4)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      check_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      bus_if.ifu_req_valid  = 1'b0;
      bus_if.ifu_req_addr   = 64'h0;
      bus_if.lsu_req_valid  = 1'b0;
      bus_if.lsu_req_addr   = 64'h0;
      bus_if.lsu_req_wen    = 1'b0;
      bus_if.lsu_req_wdata  = 64'h0;
      bus_if.lsu_req_wmask  = 8'h0;
      bus_if.mem_req_ready  = 1'b0;
      bus_if.mem_resp_valid = 1'b0;
      bus_if.mem_resp_data  = 64'h0;
   endtask

   // Called in the first ISSUE cycle; returns in the response-pulse cycle.
   task automatic mem_complete(input logic [63:0] rdata);
      bus_if.mem_req_ready = 1'b1;
      tick;
      bus_if.mem_req_ready  = 1'b0;
      bus_if.mem_resp_valid = 1'b1;
      bus_if.mem_resp_data  = rdata;
      tick;
      bus_if.mem_resp_valid = 1'b0;
      bus_if.mem_resp_data  = 64'h0;
   endtask

   task automatic ifu_read(input string tag, input logic [63:0] addr, input logic [63:0] rdata);
      bus_if.ifu_req_valid = 1'b1;
      bus_if.ifu_req_addr  = addr;
      #1;
      check_eq({tag, " ifu_ready"}, 64'(bus_if.ifu_req_ready), 64'h1);
      check_eq({tag, " lsu_ready"}, 64'(bus_if.lsu_req_ready), 64'h0);
      tick;
      bus_if.ifu_req_valid = 1'b0;
      bus_if.ifu_req_addr  = 64'hDEAD_0000_0000_0000;
      check_eq({tag, " mem_valid"}, 64'(bus_if.mem_req_valid), 64'h1);
      check_eq({tag, " mem_addr"}, bus_if.mem_req_addr, addr);
      check_eq({tag, " wen_wmask"}, 64'({bus_if.mem_req_wen, bus_if.mem_req_wmask}), 64'h0);
      mem_complete(rdata);
      check_eq({tag, " ifu_resp_valid"}, 64'(bus_if.ifu_resp_valid), 64'h1);
      check_eq({tag, " ifu_resp_data"}, bus_if.ifu_resp_data, rdata);
      check_eq({tag, " lsu_resp_valid"}, 64'(bus_if.lsu_resp_valid), 64'h0);
      tick;
      check_eq({tag, " ifu_resp_drop"}, 64'(bus_if.ifu_resp_valid), 64'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, with an IFU request pending to prove ready is held low.
      idle_inputs;
      rst_n = 1'b0;
      bus_if.ifu_req_valid = 1'b1;
      repeat (2) tick;
      check_eq("rst ifu_ready", 64'(bus_if.ifu_req_ready), 64'h0);
      check_eq("rst mem_valid", 64'(bus_if.mem_req_valid), 64'h0);
      check_eq("rst mem_addr", bus_if.mem_req_addr, 64'h0);
      check_eq("rst resp_valids", 64'({bus_if.ifu_resp_valid, bus_if.lsu_resp_valid}), 64'h0);
      check_eq("rst lsu_resp_data", bus_if.lsu_resp_data, 64'h0);
      bus_if.ifu_req_valid = 1'b0;
      rst_n = 1'b1;
      tick;

      // IFU-only read.
      ifu_read("ifu_rd", 64'h0000_0000_8000_0000, 64'h0000_0013_0010_0073);

      // LSU store held off by mem_req_ready for 5 cycles.
      bus_if.lsu_req_valid = 1'b1;
      bus_if.lsu_req_addr  = 64'h0000_0000_8000_1000;
      bus_if.lsu_req_wen   = 1'b1;
      bus_if.lsu_req_wdata = 64'h1234_5678_8765_4321;
      bus_if.lsu_req_wmask = 8'hFF;
      #1;
      check_eq("st lsu_ready", 64'(bus_if.lsu_req_ready), 64'h1);
      check_eq("st ifu_ready", 64'(bus_if.ifu_req_ready), 64'h0);
      tick;
      idle_inputs;
      for (int i = 0; i < 5; i++) begin
         check_eq("st stall valid", 64'(bus_if.mem_req_valid), 64'h1);
         check_eq("st stall addr", bus_if.mem_req_addr, 64'h0000_0000_8000_1000);
         check_eq("st stall wdata", bus_if.mem_req_wdata, 64'h1234_5678_8765_4321);
         check_eq("st stall wen_wmask", 64'({bus_if.mem_req_wen, bus_if.mem_req_wmask}), 64'h1FF);
         tick;
      end
      bus_if.mem_req_ready = 1'b1;
      tick;
      bus_if.mem_req_ready = 1'b0;
      check_eq("st single handshake", 64'(bus_if.mem_req_valid), 64'h0);
      bus_if.mem_resp_valid = 1'b1;
      bus_if.mem_resp_data  = 64'hFFFF_EEEE_DDDD_CCCC;
      tick;
      idle_inputs;
      check_eq("st lsu_resp_valid", 64'(bus_if.lsu_resp_valid), 64'h1);
      check_eq("st lsu_resp_data", bus_if.lsu_resp_data, 64'h0);
      check_eq("st ifu_resp_valid", 64'(bus_if.ifu_resp_valid), 64'h0);
      tick;
      check_eq("st lsu_resp_drop", 64'(bus_if.lsu_resp_valid), 64'h0);

      // Spurious responses in IDLE and in ISSUE are ignored.
      bus_if.mem_resp_valid = 1'b1;
      bus_if.mem_resp_data  = 64'h5555;
      tick;
      bus_if.mem_resp_valid = 1'b0;
      check_eq("spur idle resp", 64'({bus_if.ifu_resp_valid, bus_if.lsu_resp_valid}), 64'h0);
      check_eq("spur idle mem_valid", 64'(bus_if.mem_req_valid), 64'h0);
      bus_if.ifu_req_valid = 1'b1;
      bus_if.ifu_req_addr  = 64'h0000_0000_8000_0040;
      #1;
      check_eq("spur ifu_ready", 64'(bus_if.ifu_req_ready), 64'h1);
      tick;
      bus_if.ifu_req_valid  = 1'b0;
      bus_if.mem_resp_valid = 1'b1;
      bus_if.mem_resp_data  = 64'hAAAA;
      tick;
      check_eq("spur issue resp", 64'(bus_if.ifu_resp_valid), 64'h0);
      check_eq("spur issue held", 64'(bus_if.mem_req_valid), 64'h1);
      tick;
      bus_if.mem_resp_valid = 1'b0;
      check_eq("spur issue held2", 64'(bus_if.mem_req_valid), 64'h1);
      mem_complete(64'h0000_0000_1111_2222);
      check_eq("spur real resp", 64'(bus_if.ifu_resp_valid), 64'h1);
      check_eq("spur real data", bus_if.ifu_resp_data, 64'h0000_0000_1111_2222);
      tick;

      // Reset while waiting for the memory response.
      bus_if.ifu_req_valid = 1'b1;
      bus_if.ifu_req_addr  = 64'h0000_0000_8000_0080;
      tick;
      bus_if.ifu_req_valid = 1'b0;
      bus_if.mem_req_ready = 1'b1;
      tick;
      bus_if.mem_req_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      check_eq("mrst mem_valid", 64'(bus_if.mem_req_valid), 64'h0);
      check_eq("mrst mem_addr", bus_if.mem_req_addr, 64'h0);
      check_eq("mrst ifu_resp_data", bus_if.ifu_resp_data, 64'h0);
      check_eq("mrst resp_valids", 64'({bus_if.ifu_resp_valid, bus_if.lsu_resp_valid}), 64'h0);
      tick;
      rst_n = 1'b1;
      tick;
      bus_if.mem_resp_valid = 1'b1;
      bus_if.mem_resp_data  = 64'h7777;
      tick;
      bus_if.mem_resp_valid = 1'b0;
      check_eq("mrst late resp", 64'({bus_if.ifu_resp_valid, bus_if.lsu_resp_valid}), 64'h0);
      tick;
      check_eq("mrst late resp2", 64'({bus_if.ifu_resp_valid, bus_if.lsu_resp_valid}), 64'h0);
      ifu_read("post_rst", 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0097);

      // Both requesters valid continuously, starting from reset.
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_lsu_seq = 10'b10_1010_1010;
`else
      exp_lsu_seq = 10'b01_1110_1111;
`endif
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      tick;
      bus_if.ifu_req_valid = 1'b1;
      bus_if.ifu_req_addr  = 64'h0000_0000_8000_0100;
      bus_if.lsu_req_valid = 1'b1;
      bus_if.lsu_req_addr  = 64'h0000_0000_8000_2000;
      for (int k = 0; k < 10; k++) begin
         #1;
         check_eq($sformatf("prio%0d ready", k),
                  64'({bus_if.lsu_req_ready, bus_if.ifu_req_ready}),
                  exp_lsu_seq[k] ? 64'h2 : 64'h1);
         tick;
         check_eq($sformatf("prio%0d addr", k), bus_if.mem_req_addr,
                  exp_lsu_seq[k] ? 64'h0000_0000_8000_2000 : 64'h0000_0000_8000_0100);
         mem_complete(64'h1000 + 64'(k));
         check_eq($sformatf("prio%0d resp", k),
                  64'({bus_if.lsu_resp_valid, bus_if.ifu_resp_valid}),
                  exp_lsu_seq[k] ? 64'h2 : 64'h1);
         check_eq($sformatf("prio%0d data", k),
                  exp_lsu_seq[k] ? bus_if.lsu_resp_data : bus_if.ifu_resp_data,
                  64'h1000 + 64'(k));
         tick;
      end
      idle_inputs;

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
